zbb_bitcount_unit: RTL and testbench

Multi-cycle Zbb bit-count execution unit for the RV32IM_Zbb core, issuing CLZ, CTZ and CPOP from the execute stage. It owns one shared ctz_encoder instance and sequences access to it. CLZ reuses the encoder on a bit-reversed operand; CPOP is computed iteratively, one byte per cycle. Both sides use a valid/ready handshake, and a pipeline flush can kill an in-flight operation.

---
 rtl/zbb_bitcount_pkg.sv | 27 ++
 rtl/ctz_encoder.sv | 23 ++
 rtl/zbb_bitcount_unit.sv | 115 +++++++++++
 tb/tb_zbb_bitcount_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/zbb_bitcount_pkg.sv
// Shared encodings, FSM states and result sizing for the Zbb bit-count unit.
package zbb_bitcount_pkg;

   localparam int RESULT_W = 6;

   localparam logic [1:0] OP_CLZ  = 2'b00;
   localparam logic [1:0] OP_CTZ  = 2'b01;
   localparam logic [1:0] OP_CPOP = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ENC  = 2'b01,
      POP  = 2'b10,
      DONE = 2'b11
   } state_e;

   // CLZ is computed as CTZ of the mirrored operand.
   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ctz_encoder.sv
// Trailing-zero priority encoder: index of the lowest set bit.
// Latency: combinational.
// Backpressure: none; the caller decides when the output is used.
module ctz_encoder
   import zbb_bitcount_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data,
   output logic [RESULT_W-1:0]   count
);

   // Scanning downward lets the lowest set bit win. An all-zero input yields 0.
   always_comb begin
      count = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (data[i]) begin
            count = RESULT_W'(i);
         end
      end
   end

endmodule

// File: rtl/zbb_bitcount_unit.sv
// Multi-cycle CLZ/CTZ/CPOP unit sharing one trailing-zero encoder.
// Latency: CLZ/CTZ 3 cycles, CPOP 6 cycles, reserved op 2 cycles, counted from request to result.
// Backpressure: the result is held in DONE until out_ready; no request is taken while busy.
module zbb_bitcount_unit
   import zbb_bitcount_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_operand,
   input  logic [TAG_W-1:0]      in_tag,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  busy
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] operand_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [TAG_W-1:0]      tag_q;
   logic [RESULT_W-1:0]   acc_q;
   logic [RESULT_W-1:0]   acc_next;
   logic [RESULT_W-1:0]   enc_count;
   logic [1:0]            k_q;
   logic                  accept;

   function automatic logic [RESULT_W-1:0] pop8(input logic [7:0] b);
      logic [RESULT_W-1:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + RESULT_W'(b[i]);
      end
      return n;
   endfunction

   assign in_ready   = (state_q == IDLE) & ~flush;
   assign accept     = in_valid & in_ready;
   assign acc_next   = acc_q + pop8(operand_q[{k_q, 3'b000} +: 8]);
   assign out_result = result_q;
   assign out_tag    = tag_q;

   ctz_encoder #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_ctz_encoder (
      .data (operand_q),
      .count(enc_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (in_op)
                  OP_CLZ, OP_CTZ: state_d = ENC;
                  OP_CPOP:        state_d = POP;
                  default:        state_d = DONE;
               endcase
            end
         end
         ENC:  state_d = DONE;
         POP:  if (k_q == 2'd3) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // Datapath updates are suppressed under flush so a killed op never reaches result_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         operand_q <= '0;
         result_q  <= '0;
         tag_q     <= '0;
         acc_q     <= '0;
         k_q       <= '0;
      end else if (accept) begin
         operand_q <= (in_op == OP_CLZ) ? bit_rev(in_operand) : in_operand;
         tag_q     <= in_tag;
         acc_q     <= '0;
         k_q       <= '0;
         if (in_op == OP_RSVD) result_q <= '0;
      end else if (!flush) begin
         if (state_q == ENC) begin
            result_q <= (operand_q == '0) ? DATA_WIDTH'(DATA_WIDTH) : DATA_WIDTH'(enc_count);
         end else if (state_q == POP) begin
            acc_q <= acc_next;
            k_q   <= k_q + 2'd1;
            if (k_q == 2'd3) result_q <= DATA_WIDTH'(acc_next);
         end
      end
   end

endmodule

// File: tb/tb_zbb_bitcount_unit.sv
// Self-checking bench for zbb_bitcount_unit: directed table, corner sequences, random ops vs model.
module tb_zbb_bitcount_unit;
   import zbb_bitcount_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_operand;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] opd;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[10];

   zbb_bitcount_unit #(.DATA_WIDTH(32), .TAG_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_operand(in_operand),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference counts from the op definitions, not from any hardware structure.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] v);
      int n;
      n = 0;
      case (op)
         2'b00:   while (n < 32 && v[31-n] == 1'b0) n++;
         2'b01:   while (n < 32 && v[n] == 1'b0) n++;
         2'b10:   n = $countones(v);
         default: n = 0;
      endcase
      return 32'(n);
   endfunction

   // Edges from presenting the request until out_valid is seen.
   function automatic int lat_of(input logic [1:0] op);
      case (op)
         2'b10:   return 5;
         2'b11:   return 1;
         default: return 2;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] opd, input logic [31:0] exp,
                         input logic [4:0] tag, input int hold, input string name);
      int n;
      chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      in_op      = op;
      in_operand = opd;
      in_tag     = tag;
      out_ready  = (hold == 0);
      @(posedge clk); #1;
      n = 1;
      in_valid   = 1'b0;
      in_op      = 2'($urandom);
      in_operand = $urandom;
      in_tag     = 5'($urandom);
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(lat_of(op)));
      chk({name, "_result"}, out_result, exp);
      chk({name, "_tag"}, 32'(out_tag), 32'(tag));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({name, "_hold"}, {out_valid, in_ready, out_result[29:0]}, {1'b1, 1'b0, exp[29:0]});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, "_release"}, {30'd0, out_valid, busy}, 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      logic [1:0]  rop;
      logic [31:0] ropd;
      int          hold;

      vecs[0] = '{2'b01, 32'h0000_0100, 32'd8,  "ctz_100"};
      vecs[1] = '{2'b01, 32'h0000_0000, 32'd32, "ctz_0"};
      vecs[2] = '{2'b01, 32'h8000_0000, 32'd31, "ctz_msb"};
      vecs[3] = '{2'b00, 32'h0001_0000, 32'd15, "clz_10000"};
      vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'd0,  "clz_ones"};
      vecs[5] = '{2'b00, 32'h0000_0000, 32'd32, "clz_0"};
      vecs[6] = '{2'b10, 32'hF0F0_0001, 32'd9,  "cpop_f0f00001"};
      vecs[7] = '{2'b10, 32'hFFFF_FFFF, 32'd32, "cpop_ones"};
      vecs[8] = '{2'b10, 32'h0000_0000, 32'd0,  "cpop_0"};
      vecs[9] = '{2'b11, 32'h0000_1234, 32'd0,  "rsvd"};

      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_operand = '0; in_tag = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_result", out_result, 32'd0);
      chk("reset_out_tag", 32'(out_tag), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].opd, vecs[i].exp, 5'(i + 1), 0, vecs[i].name);
      end

      // Backpressure: result held for 5 cycles.
      run_op(2'b01, 32'h0000_0010, 32'd4, 5'd21, 5, "bp_ctz_10");

      // Flush in IDLE blocks acceptance.
      in_valid = 1'b1; in_op = 2'b01; in_operand = 32'h1; flush = 1'b1;
      #1 chk("flush_idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_idle_busy", 32'(busy), 32'd0);

      // Flush during POP at k=2.
      in_valid = 1'b1; in_op = 2'b10; in_operand = 32'hFFFF_FFFF; in_tag = 5'd9; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 flush = 1'b1;
      #1 chk("flush_pop_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_pop_idle", {30'd0, busy, out_valid}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      chk("flush_pop_no_valid", 32'(seen), 32'd0);
      out_ready = 1'b0;
      run_op(2'b01, 32'h0000_0004, 32'd2, 5'd3, 0, "post_flush_ctz_4");

      // Asynchronous reset mid-ENC.
      in_valid = 1'b1; in_op = 2'b01; in_operand = 32'h0000_0100; in_tag = 5'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_out_tag", 32'(out_tag), 32'd0);
      chk("async_rst_out_result", out_result, 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", {30'd0, busy, out_valid}, 32'd0);
      run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 5'd17, 0, "post_rst_rsvd");

      for (int i = 0; i < 150; i++) begin
         rop  = 2'($urandom_range(0, 3));
         ropd = $urandom;
         case ($urandom_range(0, 3))
            0: ropd = ropd >> $urandom_range(0, 32);
            1: ropd = ropd << $urandom_range(0, 32);
            2: ropd = ropd & $urandom;
            default: ;
         endcase
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op(rop, ropd, model(rop, ropd), 5'($urandom), hold, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
